// File: rtl/dff_monitor.sv
// Reference-model checker for a single-bit flop: tracks d, compares q/qb each
// clock in CHECK, and reports mismatches as a pulse, sticky flag and counters.
module dff_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SETTLE      = 2,
  parameter logic        RST_VAL     = 1'b0,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             qb,
  input  logic             clr,
  output logic             exp_q,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             model_q, model_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic             mismatch;
  logic             do_cmp;

  // Case equality so X/Z on q/qb counts as a mismatch in simulation.
  assign mismatch = (q !== model_q) || (qb !== ~q);
  assign do_cmp   = (state_q == ST_CHECK) && en;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    model_d   = d;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        settle_d = '0;
        state_d  = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
        else                         settle_d = settle_q + 4'd1;
      end
      ST_CHECK: begin
        if (do_cmp && mismatch && STOP_ON_ERR) state_d = ST_HALT;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase

    if (do_cmp) begin
      chk_cnt_d = (chk_cnt_q == '1) ? chk_cnt_q : chk_cnt_q + 1'b1;
      if (mismatch) begin
        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
        sticky_d  = 1'b1;
        err_d     = 1'b1;
      end
    end

    // clr overrides this edge's compare result, including a pending HALT entry.
    if (clr && (state_q != ST_IDLE)) begin
      err_cnt_d = '0;
      chk_cnt_d = '0;
      sticky_d  = 1'b0;
      err_d     = 1'b0;
      if (state_q == ST_CHECK || state_q == ST_HALT) state_d = ST_CHECK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      model_q   <= RST_VAL;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      model_q   <= model_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign exp_q       = model_q;
  assign err         = err_q;
  assign err_sticky  = sticky_q;
  assign err_count   = err_cnt_q;
  assign check_count = chk_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_dff_monitor.sv
// Bench for dff_monitor: two parameterisations driven by shared stimulus and
// checked every cycle against a cycle-count based behavioural model.
module tb_dff_monitor;

  localparam int P_W    [2] = '{3, 8};
  localparam int P_SET  [2] = '{2, 0};
  localparam int P_RV   [2] = '{0, 1};
  localparam int P_STOP [2] = '{0, 1};

  localparam int M_OK = 0, M_STUCK = 1, M_COMPL = 2, M_RAND = 3;

  logic       clk = 1'b0;
  logic       reset, en_s, d_s, clr_s, rq, rqb;
  logic       fq = 1'b0;
  int         mode;
  logic       q_s, qb_s;

  logic       exp_a, err_a, stk_a, exp_b, err_b, stk_b;
  logic [2:0] ec_a, cc_a;
  logic [7:0] ec_b, cc_b;
  logic [1:0] st_a, st_b;

  int checks = 0;
  int errors = 0;

  logic m_exp    [2];
  logic m_err    [2];
  logic m_sticky [2];
  logic m_halt   [2];
  int   m_ec     [2];
  int   m_cc     [2];
  int   m_rel    [2];

  always #5 clk = ~clk;

  always @(posedge clk) fq <= d_s;

  always_comb begin
    q_s  = fq;
    qb_s = ~fq;
    case (mode)
      M_STUCK: begin q_s = 1'b0; qb_s = 1'b1; end
      M_COMPL: begin q_s = fq;   qb_s = fq;   end
      M_RAND:  begin q_s = rq;   qb_s = rqb;  end
      default: ;
    endcase
  end

  dff_monitor #(.CNT_W(3), .SETTLE(2), .RST_VAL(1'b0), .STOP_ON_ERR(1'b0)) u_a (
    .clk(clk), .reset(reset), .en(en_s), .d(d_s), .q(q_s), .qb(qb_s), .clr(clr_s),
    .exp_q(exp_a), .err(err_a), .err_sticky(stk_a), .err_count(ec_a),
    .check_count(cc_a), .state(st_a));

  dff_monitor #(.CNT_W(8), .SETTLE(0), .RST_VAL(1'b1), .STOP_ON_ERR(1'b1)) u_b (
    .clk(clk), .reset(reset), .en(en_s), .d(d_s), .q(q_s), .qb(qb_s), .clr(clr_s),
    .exp_q(exp_b), .err(err_b), .err_sticky(stk_b), .err_count(ec_b),
    .check_count(cc_b), .state(st_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: state is derived from edges seen since reset release and a halt flag.
  function automatic int m_state(input int k);
    if (m_rel[k] == 0)          return 0;
    if (m_rel[k] <= P_SET[k])   return 1;
    return m_halt[k] ? 3 : 2;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_exp[k]    <= P_RV[k][0];
        m_err[k]    <= 1'b0;
        m_sticky[k] <= 1'b0;
        m_halt[k]   <= 1'b0;
        m_ec[k]     <= 0;
        m_cc[k]     <= 0;
        m_rel[k]    <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int   maxv = (1 << P_W[k]) - 1;
        automatic int   ec = m_ec[k], cc = m_cc[k];
        automatic logic stk = m_sticky[k], hlt = m_halt[k], perr = 1'b0;
        automatic logic bad = !((q_s === m_exp[k]) && (qb_s === !q_s));
        if ((m_rel[k] > P_SET[k]) && !m_halt[k] && en_s) begin
          cc = (cc < maxv) ? cc + 1 : cc;
          if (bad) begin
            ec   = (ec < maxv) ? ec + 1 : ec;
            stk  = 1'b1;
            perr = 1'b1;
            if (P_STOP[k] != 0) hlt = 1'b1;
          end
        end
        if (clr_s && m_rel[k] > 0) begin
          ec = 0; cc = 0; stk = 1'b0; perr = 1'b0; hlt = 1'b0;
        end
        m_ec[k]     <= ec;
        m_cc[k]     <= cc;
        m_sticky[k] <= stk;
        m_halt[k]   <= hlt;
        m_err[k]    <= perr;
        m_exp[k]    <= d_s;
        m_rel[k]    <= (m_rel[k] < 1000) ? m_rel[k] + 1 : m_rel[k];
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_exp_a", exp_a, m_exp[0]);
    chk("cyc_err_a", err_a, m_err[0]);
    chk("cyc_stk_a", stk_a, m_sticky[0]);
    chk("cyc_ec_a",  ec_a,  m_ec[0]);
    chk("cyc_cc_a",  cc_a,  m_cc[0]);
    chk("cyc_st_a",  st_a,  m_state(0));
    chk("cyc_exp_b", exp_b, m_exp[1]);
    chk("cyc_err_b", err_b, m_err[1]);
    chk("cyc_stk_b", stk_b, m_sticky[1]);
    chk("cyc_ec_b",  ec_b,  m_ec[1]);
    chk("cyc_cc_b",  cc_b,  m_cc[1]);
    chk("cyc_st_b",  st_b,  m_state(1));
  end

  task automatic tick(input logic dv, input logic ev, input logic cv, input int mv);
    d_s   = dv;
    en_s  = ev;
    clr_s = cv;
    mode  = mv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] pat;
    reset = 1'b0; en_s = 1'b0; d_s = 1'b0; clr_s = 1'b0; mode = M_OK;
    rq = 1'b0; rqb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_a", st_a, 0);
    chk("rst_exp_a", exp_a, 0);
    chk("rst_exp_b", exp_b, 1);
    chk("rst_cc_a", cc_a, 0);

    reset = 1'b1;
    tick(1, 1, 0, M_OK); chk("settle_st1", st_a, 1);
    tick(1, 1, 0, M_OK); chk("settle_st2", st_a, 1);
    tick(1, 1, 0, M_OK); chk("settle_st3", st_a, 2);
    chk("settle_nocmp", cc_a, 0);

    pat = 5'b01101;
    for (int i = 4; i >= 0; i--) begin
      tick(pat[i], 1, 0, M_OK);
      chk("healthy_err", err_a, 0);
    end
    chk("healthy_cc", cc_a, 5);
    chk("healthy_ec", ec_a, 0);

    tick(1, 1, 1, M_OK); chk("clr_cc", cc_a, 0);
    tick(1, 1, 0, M_STUCK); chk("stuck_err1", err_a, 1);
    chk("halt_st_b", st_b, 3);
    chk("halt_ec_b", ec_b, 1);
    tick(1, 1, 0, M_STUCK); chk("stuck_err2", err_a, 1);
    tick(1, 1, 0, M_STUCK); chk("stuck_err3", err_a, 1);
    chk("stuck_ec", ec_a, 3);
    chk("stuck_stk", stk_a, 1);
    tick(0, 1, 0, M_OK);
    chk("stuck_err_end", err_a, 0);
    chk("halt_exp_b", exp_b, 0);
    chk("halt_frozen_b", ec_b, 1);

    tick(0, 1, 1, M_COMPL);
    chk("clr_halt_st_b", st_b, 2);
    chk("clr_compl_err", err_a, 0);
    tick(1, 1, 0, M_COMPL); chk("compl_ec1", ec_a, 1);
    chk("compl_halt_b", st_b, 3);
    tick(0, 1, 0, M_COMPL); chk("compl_ec2", ec_a, 2);
    chk("compl_frozen_b", ec_b, 1);
    chk("compl_exp_b", exp_b, 0);

    tick(1, 1, 1, M_STUCK);
    repeat (10) tick(1, 1, 0, M_STUCK);
    chk("sat_ec", ec_a, 7);
    chk("sat_cc", cc_a, 7);
    tick(1, 1, 1, M_STUCK);
    chk("satclr_ec", ec_a, 0);
    chk("satclr_cc", cc_a, 0);
    chk("satclr_stk", stk_a, 0);
    chk("satclr_err", err_a, 0);

    repeat (4) tick(1, 1, 0, M_STUCK);
    chk("mid_ec", ec_a, 4);
    reset = 1'b0;
    #1;
    chk("mid_st", st_a, 0);
    chk("mid_ec0", ec_a, 0);
    chk("mid_cc0", cc_a, 0);
    chk("mid_stk0", stk_a, 0);
    chk("mid_err0", err_a, 0);
    chk("mid_exp0", exp_a, 0);
    chk("mid_exp_b", exp_b, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    tick(0, 1, 0, M_OK); chk("rerun_st1", st_a, 1);
    tick(0, 1, 0, M_OK); chk("rerun_st2", st_a, 1);
    tick(0, 1, 0, M_OK); chk("rerun_st3", st_a, 2);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      rq    = 1'($urandom_range(0, 1));
      rqb   = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
    end
    reset = 1'b1;
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
